chain_mult_engine: RTL and testbench
====================================

// Module: chain_mult_engine
// PURPOSE
//  Hardware product accelerator: on a falling edge of start, reads n_ops W-bit operands from data
//  memory at src_base, computes their product as a PW-bit value and writes it little-endian at dst_base.
//  Operands are signed (two's comp) or unsigned per is_signed. Raises done when the result is stored.
//  Sits beside the core as a second master on the byte-wide data memory port.
// PARAMETERS
//  W      8    operand width, bits
//  N_MAX  3    max operands per product; operand count is runtime n_ops
//  PW     W*N_MAX  product width, bits; must be a multiple of 8 (NB = PW/8 result bytes)
//  AW     8    data memory address width
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  start        in   1        falling edge (sampled 1 then 0) launches one operation
//  done         out  1        high from store completion until start next samples 1
//  n_ops        in   $clog2(N_MAX+1)  operand count, captured at launch
//  is_signed    in   1        1 = two's comp operands/result, 0 = unsigned; captured at launch
//  src_base     in   AW       address of operand 0; operand k at src_base+k
//  dst_base     in   AW       address of result byte 0 (LSB); byte j at dst_base+j
//  mem_addr     out  AW       data memory address
//  mem_rd_data  in   W        read data; combinational read of mem_addr, same cycle
//  mem_wr_en    out  1        byte write strobe, written on the rising edge
//  mem_wr_data  out  8        write byte
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, start_q=0,
//   all datapath regs 0. Asserting reset mid-operation aborts at once; bytes already written stay.
//  start_q resets to 0: start held low through reset release does NOT launch; a 1->0 sample is required.
//  FSM: IDLE -> FIRST -> (LOAD -> MUL x W)*(n-1) -> FIX -> STORE x NB -> DONE -> IDLE.
//   IDLE : on start_q=1 & start=0 capture n_ops (clamped to N_MAX), is_signed, bases; go FIRST.
//   FIRST: read op0 at src_base; acc=|op0| (zero-extended if unsigned), neg=sign(op0)&is_signed.
//          n_ops==0: acc=1, neg=0, skip to FIX (empty product = 1).
//   LOAD : read op k; Q=|op k|, M=acc, P=0, neg^=sign(op k)&is_signed.
//   MUL  : one shift-add step per cycle: if Q[0] P+=M; M<<=1; Q>>=1; after W steps acc=P.
//   FIX  : result = neg ? -acc : acc (mod 2^PW).
//   STORE: byte j = result[8j+7:8j] to dst_base+j, j=0..NB-1, one byte/cycle, mem_wr_en=1.
//   DONE : done=1; hold until start samples 1, then done=0 and IDLE.
//  Arithmetic: magnitudes are PW-bit unsigned; with n_ops<=N_MAX the product never overflows PW bits
//   (signed worst case (-2^(W-1))^N_MAX fits). Address increments wrap mod 2^AW.
//  Latency, n>=1: 1 + (n-1)(W+1) + 1 + NB cycles from the launch edge to done=1 (W=8,n=3: 23).
//  start falling edges while not IDLE are ignored. mem_wr_en=0 in every state except STORE.
//  mem_addr is driven only in FIRST/LOAD/STORE, held at 0 otherwise.
// STRUCTURE
//  Package chain_mult_pkg: state_t enum {IDLE,FIRST,LOAD,MUL,FIX,STORE,DONE}, defaults W/N_MAX,
//   function magnitude(op,is_signed).
//  Sub-module seq_umul: PW-bit iterative shift-add unsigned multiplier (load/step/busy). The FSM,
//   sign tracking and the memory sequencer stay in the top.
// TESTING
//  1 defaults, signed, n=3, mem[0..2]=2,4,8 -> mem[3..5]=40,00,00 hex; done at cycle 23
//  2 signed -128,-128,-128 -> E00000 (bytes 00,00,E0); 127,-1,0 -> 000000
//  3 unsigned 255,255,255 -> FD02FF (bytes FF,02,FD); signed n=1 op -5 -> FFFFFB; n=0 -> 000001
//  4 2nd start falling edge at cycle 10 -> ignored; exactly 3 writes; done stays high while start=0
//  5 reset=0 during 2nd STORE cycle -> done=0, mem_wr_en=0 same cycle; dst+2 not written; re-launch ok
//  6 start held low across reset release -> no launch until start goes 1 then 0

Source files
------------

// File: rtl/chain_mult_pkg.sv
`default_nettype none
//==============================================================================
// Package  : chain_mult_pkg
// Purpose  : Shared types, default sizes and the operand-magnitude helper used
//            by chain_mult_engine.
// Revision : 1.0
//==============================================================================
package chain_mult_pkg;

   localparam int c_def_w     = 8;
   localparam int c_def_n_max = 3;
   localparam int c_max_w     = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FIRST = 3'd1,
      LOAD  = 3'd2,
      MUL   = 3'd3,
      FIX   = 3'd4,
      STORE = 3'd5,
      DONE  = 3'd6
   } state_t;

   // op arrives already extended to c_max_w bits; the caller truncates the result
   function automatic logic [c_max_w-1:0] magnitude(input logic [c_max_w-1:0] op,
                                                    input logic                is_signed);
      magnitude = (is_signed && op[c_max_w-1]) ? -op : op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_umul.sv
`default_nettype none
//==============================================================================
// Module   : seq_umul
// Purpose  : Iterative shift-add unsigned multiplier, one multiplier bit per step.
// Revision : 1.0
//==============================================================================
module seq_umul #(
   parameter int W  = 8,
   parameter int PW = 24
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          step,
   input  logic [PW-1:0] multiplicand,
   input  logic [W-1:0]  multiplier,
   output logic [PW-1:0] product,
   output logic          busy,
   output logic          last
);
   localparam int c_cw = $clog2(W + 1);

   logic [PW-1:0]   r_m;
   logic [PW-1:0]   r_p;
   logic [W-1:0]    r_q;
   logic [c_cw-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m   <= '0;
         r_p   <= '0;
         r_q   <= '0;
         r_cnt <= '0;
      end else if (load) begin
         r_m   <= multiplicand;
         r_p   <= '0;
         r_q   <= multiplier;
         r_cnt <= c_cw'(W);
      end else if (step && busy) begin
         if (r_q[0]) begin
            r_p <= r_p + r_m;
         end
         r_m   <= r_m << 1;
         r_q   <= r_q >> 1;
         r_cnt <= r_cnt - c_cw'(1);
      end
   end

   assign product = r_p;
   assign busy    = (r_cnt != '0);
   // high during the final step so the caller can leave without an idle cycle
   assign last    = (r_cnt == c_cw'(1));

endmodule
`default_nettype wire

// File: rtl/chain_mult_engine.sv
`default_nettype none
//==============================================================================
// Module   : chain_mult_engine
// Purpose  : Memory-mastering product engine: reads n_ops operands, multiplies
//            them and stores the PW-bit product little-endian at dst_base.
// Revision : 1.0
//==============================================================================
module chain_mult_engine
   import chain_mult_pkg::*;
#(
   parameter int W     = c_def_w,
   parameter int N_MAX = c_def_n_max,
   parameter int PW    = W * N_MAX,
   parameter int AW    = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic                       done,
   input  logic [$clog2(N_MAX+1)-1:0] n_ops,
   input  logic                       is_signed,
   input  logic [AW-1:0]              src_base,
   input  logic [AW-1:0]              dst_base,
   output logic [AW-1:0]              mem_addr,
   input  logic [W-1:0]               mem_rd_data,
   output logic                       mem_wr_en,
   output logic [7:0]                 mem_wr_data
);
   localparam int              c_nw    = $clog2(N_MAX + 1);
   localparam int              c_nb    = PW / 8;
   localparam int              c_bw    = $clog2(c_nb + 1);
   localparam logic [c_nw-1:0] c_n_max = c_nw'(N_MAX);

   state_t          r_state;
   state_t          w_next;
   logic            r_start_q;
   logic [c_nw-1:0] r_n;
   logic            r_sgn;
   logic [AW-1:0]   r_src;
   logic [AW-1:0]   r_dst;
   logic [c_nw-1:0] r_k;
   logic            r_neg;
   logic [PW-1:0]   r_acc;
   logic            r_acc_in_mul;
   logic [PW-1:0]   r_result;
   logic [c_bw-1:0] r_bidx;

   logic               w_launch;
   logic [c_nw-1:0]    w_n_clamped;
   logic [c_max_w-1:0] w_op_ext;
   logic [W-1:0]       w_mag;
   logic               w_opneg;
   logic [PW-1:0]      w_acc;
   logic [PW-1:0]      w_product;
   logic [PW-1:0]      w_shifted;
   logic               w_mul_load;
   logic               w_mul_step;
   logic               w_mul_busy;
   logic               w_mul_last;

   assign w_launch    = r_start_q && !start;
   assign w_n_clamped = (n_ops > c_n_max) ? c_n_max : n_ops;
   assign w_op_ext    = {{(c_max_w-W){r_sgn & mem_rd_data[W-1]}}, mem_rd_data};
   assign w_mag       = W'(magnitude(w_op_ext, r_sgn));
   assign w_opneg     = r_sgn & mem_rd_data[W-1];
   // once a multiply has finished the running product lives in the multiplier
   assign w_acc       = r_acc_in_mul ? w_product : r_acc;
   assign w_shifted   = r_result >> {r_bidx, 3'b000};
   assign done        = (r_state == DONE);

   seq_umul #(
      .W  (W),
      .PW (PW)
   ) u_seq_umul (
      .clk          (clk),
      .reset        (reset),
      .load         (w_mul_load),
      .step         (w_mul_step),
      .multiplicand (w_acc),
      .multiplier   (w_mag),
      .product      (w_product),
      .busy         (w_mul_busy),
      .last         (w_mul_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      w_mul_load  = 1'b0;
      w_mul_step  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_launch) begin
               w_next = FIRST;
            end
         end
         FIRST: begin
            mem_addr = r_src;
            w_next   = (r_n > c_nw'(1)) ? LOAD : FIX;
         end
         LOAD: begin
            mem_addr   = r_src + AW'(r_k);
            w_mul_load = 1'b1;
            w_next     = MUL;
         end
         MUL: begin
            w_mul_step = w_mul_busy;
            if (w_mul_last) begin
               w_next = (r_k == r_n - c_nw'(1)) ? FIX : LOAD;
            end
         end
         FIX: begin
            w_next = STORE;
         end
         STORE: begin
            mem_addr    = r_dst + AW'(r_bidx);
            mem_wr_en   = 1'b1;
            mem_wr_data = w_shifted[7:0];
            if (r_bidx == c_bw'(c_nb - 1)) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_start_q    <= 1'b0;
         r_n          <= '0;
         r_sgn        <= 1'b0;
         r_src        <= '0;
         r_dst        <= '0;
         r_k          <= '0;
         r_neg        <= 1'b0;
         r_acc        <= '0;
         r_acc_in_mul <= 1'b0;
         r_result     <= '0;
         r_bidx       <= '0;
      end else begin
         r_start_q <= start;
         case (r_state)
            IDLE: begin
               if (w_launch) begin
                  r_n          <= w_n_clamped;
                  r_sgn        <= is_signed;
                  r_src        <= src_base;
                  r_dst        <= dst_base;
                  r_k          <= '0;
                  r_bidx       <= '0;
                  r_acc_in_mul <= 1'b0;
               end
            end
            FIRST: begin
               r_k <= c_nw'(1);
               if (r_n == '0) begin
                  r_acc <= PW'(1);
                  r_neg <= 1'b0;
               end else begin
                  r_acc <= PW'(w_mag);
                  r_neg <= w_opneg;
               end
            end
            LOAD: begin
               r_neg <= r_neg ^ w_opneg;
            end
            MUL: begin
               if (w_mul_last) begin
                  r_k          <= r_k + c_nw'(1);
                  r_acc_in_mul <= 1'b1;
               end
            end
            FIX: begin
               r_result <= r_neg ? -w_acc : w_acc;
            end
            STORE: begin
               r_bidx <= r_bidx + c_bw'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_chain_mult_engine.sv
`default_nettype none
//==============================================================================
// Module   : tb_chain_mult_engine
// Purpose  : Self-checking bench for chain_mult_engine against an integer
//            product model.
// Revision : 1.0
//==============================================================================
module tb_chain_mult_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       done;
   logic [1:0] n_ops;
   logic       is_signed;
   logic [7:0] src_base;
   logic [7:0] dst_base;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;

   logic [7:0] rom    [0:255];
   logic [7:0] wa_log [0:1023];
   logic [7:0] wd_log [0:1023];
   int         wr_total = 0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign mem_rd_data = rom[mem_addr];

   always @(posedge clk) begin
      if (mem_wr_en === 1'b1 && wr_total < 1024) begin
         wa_log[wr_total] <= mem_addr;
         wd_log[wr_total] <= mem_wr_data;
         wr_total         <= wr_total + 1;
      end
   end

   chain_mult_engine dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .done        (done),
      .n_ops       (n_ops),
      .is_signed   (is_signed),
      .src_base    (src_base),
      .dst_base    (dst_base),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data)
   );

   // product of the first n operands, reduced mod 2^24
   function automatic logic [23:0] ref_product(input int n, input bit sgn,
                                               input logic [7:0] o0, input logic [7:0] o1,
                                               input logic [7:0] o2);
      longint     p;
      longint     v;
      logic [7:0] ops [3];
      ops[0] = o0;
      ops[1] = o1;
      ops[2] = o2;
      p = 1;
      for (int k = 0; k < n; k++) begin
         v = sgn ? longint'($signed(ops[k])) : longint'(ops[k]);
         p = p * v;
      end
      return p[23:0];
   endfunction

   function automatic int lat_ref(input int n);
      return 1 + ((n > 1) ? (n - 1) * 9 : 0) + 1 + 3;
   endfunction

   task automatic launch_and_wait(input int n, input bit sgn, input logic [7:0] src,
                                  input logic [7:0] dst, output int lat);
      n_ops     = 2'(n);
      is_signed = sgn;
      src_base  = src;
      dst_base  = dst;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done === 1'b1) begin
            lat = c;
            break;
         end
      end
      start = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic collect(input int base, input logic [7:0] dst, output logic [23:0] val,
                          output int nwr, output bit addr_ok);
      nwr     = wr_total - base;
      val     = '0;
      addr_ok = 1'b1;
      for (int j = 0; j < 3; j++) begin
         if (base + j < 1024) begin
            val[8*j +: 8] = wd_log[base + j];
            if (wa_log[base + j] !== 8'(dst + j)) addr_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      start     = 1'b0;
      n_ops     = '0;
      is_signed = 1'b0;
      src_base  = '0;
      dst_base  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++;
      if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
      n_cmp++;
      if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
      n_cmp++;
      if (mem_wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_wr_data: got %h want 00", mem_wr_data); end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_start_held_low();
      int          base;
      int          lat;
      int          nwr;
      bit          idle_ok;
      bit          aok;
      logic [23:0] val;
      base    = wr_total;
      idle_ok = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || mem_addr !== 8'h00) idle_ok = 1'b0;
      end
      n_cmp++;
      if (idle_ok !== 1'b1) begin n_bad++; $display("FAIL held_low_idle: got %b want 1", idle_ok); end
      n_cmp++;
      if (wr_total - base !== 0) begin n_bad++; $display("FAIL held_low_writes: got %0d want 0", wr_total - base); end
      rom[8'h10] = 8'd3;
      rom[8'h11] = 8'd5;
      rom[8'h12] = 8'd7;
      base = wr_total;
      launch_and_wait(3, 1'b0, 8'h10, 8'h60, lat);
      collect(base, 8'h60, val, nwr, aok);
      n_cmp++;
      if (val !== 24'h000069) begin n_bad++; $display("FAIL held_low_result: got %h want 000069", val); end
      n_cmp++;
      if (lat !== 23) begin n_bad++; $display("FAIL held_low_latency: got %0d want 23", lat); end
   endtask

   task automatic test_basic();
      int          base;
      int          lat;
      int          nwr;
      bit          aok;
      logic [23:0] val;
      rom[0] = 8'd2;
      rom[1] = 8'd4;
      rom[2] = 8'd8;
      base = wr_total;
      launch_and_wait(3, 1'b1, 8'h00, 8'h03, lat);
      collect(base, 8'h03, val, nwr, aok);
      n_cmp++;
      if (lat !== 23) begin n_bad++; $display("FAIL basic_latency: got %0d want 23", lat); end
      n_cmp++;
      if (nwr !== 3) begin n_bad++; $display("FAIL basic_writes: got %0d want 3", nwr); end
      n_cmp++;
      if (aok !== 1'b1) begin n_bad++; $display("FAIL basic_addresses: got %b want 1", aok); end
      n_cmp++;
      if (val !== 24'h000040) begin n_bad++; $display("FAIL basic_result: got %h want 000040", val); end
   endtask

   task automatic test_corners();
      int          cn [5];
      bit          cs [5];
      logic [7:0]  co [5][3];
      logic [23:0] ce [5];
      int          base;
      int          lat;
      int          nwr;
      bit          aok;
      logic [23:0] val;
      cn = '{3, 3, 3, 1, 0};
      cs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      co = '{'{8'h80, 8'h80, 8'h80}, '{8'h7F, 8'hFF, 8'h00}, '{8'hFF, 8'hFF, 8'hFF},
             '{8'hFB, 8'h11, 8'h22}, '{8'h33, 8'h44, 8'h55}};
      ce = '{24'hE00000, 24'h000000, 24'hFD02FF, 24'hFFFFFB, 24'h000001};
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 3; k++) rom[8'h20 + k] = co[i][k];
         base = wr_total;
         launch_and_wait(cn[i], cs[i], 8'h20, 8'h40, lat);
         collect(base, 8'h40, val, nwr, aok);
         n_cmp++;
         if (val !== ce[i] || nwr !== 3 || aok !== 1'b1) begin
            n_bad++;
            $display("FAIL corner_%0d_result: got %h (%0d writes, addr_ok %b) want %h (3 writes)",
                     i, val, nwr, aok, ce[i]);
         end
         n_cmp++;
         if (lat !== lat_ref(cn[i])) begin
            n_bad++;
            $display("FAIL corner_%0d_latency: got %0d want %0d", i, lat, lat_ref(cn[i]));
         end
      end
   endtask

   task automatic test_random();
      int          n;
      bit          sgn;
      logic [7:0]  src;
      logic [7:0]  dst;
      logic [7:0]  o [3];
      logic [23:0] exp_val;
      int          base;
      int          lat;
      int          nwr;
      bit          aok;
      logic [23:0] val;
      for (int it = 0; it < 16; it++) begin
         n   = int'($urandom_range(0, 3));
         sgn = 1'($urandom_range(0, 1));
         src = 8'($urandom);
         dst = 8'($urandom);
         for (int k = 0; k < 3; k++) begin
            o[k] = 8'($urandom);
            rom[8'(src + k)] = o[k];
         end
         exp_val = ref_product(n, sgn, o[0], o[1], o[2]);
         base    = wr_total;
         launch_and_wait(n, sgn, src, dst, lat);
         collect(base, dst, val, nwr, aok);
         n_cmp++;
         if (val !== exp_val || nwr !== 3 || aok !== 1'b1) begin
            n_bad++;
            $display("FAIL random_%0d_result: n=%0d s=%b got %h (%0d writes, addr_ok %b) want %h",
                     it, n, sgn, val, nwr, aok, exp_val);
         end
         n_cmp++;
         if (lat !== lat_ref(n)) begin
            n_bad++;
            $display("FAIL random_%0d_latency: got %0d want %0d", it, lat, lat_ref(n));
         end
      end
   endtask

   task automatic test_ignore_start();
      int          base;
      int          lat;
      int          nwr;
      bit          aok;
      bit          held;
      logic [23:0] val;
      logic [23:0] exp_val;
      rom[8'h70] = 8'hF6;
      rom[8'h71] = 8'h0D;
      rom[8'h72] = 8'h9C;
      exp_val   = ref_product(3, 1'b1, 8'hF6, 8'h0D, 8'h9C);
      base      = wr_total;
      n_ops     = 2'd3;
      is_signed = 1'b1;
      src_base  = 8'h70;
      dst_base  = 8'h90;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk);
         #1;
         if (c == 8) start = 1'b1;
         if (c == 10) start = 1'b0;
         @(negedge clk);
         if (done === 1'b1) begin
            lat = c;
            break;
         end
      end
      n_cmp++;
      if (lat !== 23) begin n_bad++; $display("FAIL ignore_latency: got %0d want 23", lat); end
      held = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done !== 1'b1) held = 1'b0;
      end
      n_cmp++;
      if (held !== 1'b1) begin n_bad++; $display("FAIL ignore_done_hold: got %b want 1", held); end
      collect(base, 8'h90, val, nwr, aok);
      n_cmp++;
      if (nwr !== 3) begin n_bad++; $display("FAIL ignore_writes: got %0d want 3", nwr); end
      n_cmp++;
      if (val !== exp_val || aok !== 1'b1) begin
         n_bad++;
         $display("FAIL ignore_result: got %h (addr_ok %b) want %h", val, aok, exp_val);
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL ignore_done_clear: got %b want 0", done); end
   endtask

   task automatic test_reset_midstore();
      int          base;
      int          lat;
      int          nwr;
      bit          aok;
      logic [23:0] val;
      logic [23:0] exp_val;
      rom[8'h30] = 8'h81;
      rom[8'h31] = 8'h03;
      rom[8'h32] = 8'h7F;
      exp_val   = ref_product(3, 1'b1, 8'h81, 8'h03, 8'h7F);
      base      = wr_total;
      n_ops     = 2'd3;
      is_signed = 1'b1;
      src_base  = 8'h30;
      dst_base  = 8'h50;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      repeat (21) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 8'h51) begin
         n_bad++;
         $display("FAIL midstore_position: got wr_en %b addr %h want 1 51", mem_wr_en, mem_addr);
      end
      #1 reset = 1'b0;
      #1;
      n_cmp++;
      if (done !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== 8'h00) begin
         n_bad++;
         $display("FAIL midstore_abort: got done %b wr_en %b addr %h want 0 0 00",
                  done, mem_wr_en, mem_addr);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      nwr = wr_total - base;
      n_cmp++;
      if (nwr !== 1) begin n_bad++; $display("FAIL midstore_writes: got %0d want 1", nwr); end
      n_cmp++;
      if (wa_log[base] !== 8'h50 || wd_log[base] !== exp_val[7:0]) begin
         n_bad++;
         $display("FAIL midstore_byte0: got %h@%h want %h@50", wd_log[base], wa_log[base], exp_val[7:0]);
      end
      base = wr_total;
      launch_and_wait(3, 1'b1, 8'h30, 8'h50, lat);
      collect(base, 8'h50, val, nwr, aok);
      n_cmp++;
      if (val !== exp_val || nwr !== 3 || aok !== 1'b1) begin
         n_bad++;
         $display("FAIL midstore_relaunch: got %h (%0d writes, addr_ok %b) want %h", val, nwr, aok, exp_val);
      end
      n_cmp++;
      if (lat !== 23) begin n_bad++; $display("FAIL midstore_relaunch_latency: got %0d want 23", lat); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int a = 0; a < 256; a++) rom[a] = 8'h00;
      test_reset();
      test_start_held_low();
      test_basic();
      test_corners();
      test_random();
      test_ignore_start();
      test_reset_midstore();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
